// File: rtl/mc_burst_addr_gen_if.sv
// Handshake and control bundle for the burst address generator.
// The master side requests bursts and accepts beats; the slave side is the generator.
interface mc_burst_addr_gen_if #(
  parameter int AW = 24
);
  logic          start;
  logic [AW-1:0] start_addr;
  logic [2:0]    bl_code;
  logic          wrap_mode;
  logic          stop;
  logic [AW-1:0] addr_out;
  logic          addr_vld;
  logic          addr_rdy;
  logic          last;
  logic          busy;
  logic          done;

  modport master (
    output start, start_addr, bl_code, wrap_mode, stop, addr_rdy,
    input  addr_out, addr_vld, last, busy, done
  );

  modport slave (
    input  start, start_addr, bl_code, wrap_mode, stop, addr_rdy,
    output addr_out, addr_vld, last, busy, done
  );
endinterface

// File: rtl/mc_burst_addr_gen.sv
// Burst address generator: captures a start address and SDRAM burst code,
// then presents one address per beat over a valid/ready handshake.
// Linear, wrapped and full-page bursts share one incrementer: a per-burst
// mask selects which address bits take part in the +1, the rest hold.
module mc_burst_addr_gen #(
  parameter int AW   = 24,
  parameter int COLW = 8
) (
  input  logic               clk,
  input  logic               rst,
  mc_burst_addr_gen_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW-1:0] PAGE_MASK  = AW'((1 << COLW) - 1);
  localparam logic [COLW:0] PAGE_BEATS = {1'b1, {COLW{1'b0}}};

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] mask_q, mask_d;
  logic [COLW:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [COLW:0] beats;
  logic [AW-1:0] beat_mask;
  logic [AW-1:0] next_addr;
  logic          xfer;

  assign xfer = vld_q & bus.addr_rdy;

  // Masked increment: bits inside mask_q count, bits outside stay put.
  assign next_addr = (addr_q & ~mask_q) | ((addr_q + AW'(1)) & mask_q);

  // Decode burst code into beat count and increment mask.
  always_comb begin
    beats     = (COLW+1)'(1);
    beat_mask = '0;
    case (bus.bl_code)
      3'd1: begin beats = (COLW+1)'(2); beat_mask = AW'(1); end
      3'd2: begin beats = (COLW+1)'(4); beat_mask = AW'(3); end
      3'd3: begin beats = (COLW+1)'(8); beat_mask = AW'(7); end
      3'd7: begin beats = PAGE_BEATS;   beat_mask = PAGE_MASK; end
      default: begin beats = (COLW+1)'(1); beat_mask = '0; end
    endcase
    // Linear bursts carry across the whole address; full page always wraps.
    if (!bus.wrap_mode && bus.bl_code != 3'd7) beat_mask = '1;
  end

  // Next-state logic for the IDLE/RUN controller and its registered outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          addr_d  = bus.start_addr;
          mask_d  = beat_mask;
          cnt_d   = beats;
          vld_d   = 1'b1;
          last_d  = (beats == (COLW+1)'(1));
        end
      end
      RUN: begin
        // Stop wins over a normal advance; a coincident xfer still counts.
        if (bus.stop || (xfer && cnt_q == (COLW+1)'(1))) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (xfer) begin
          addr_d = next_addr;
          cnt_d  = cnt_q - (COLW+1)'(1);
          last_d = (cnt_q == (COLW+1)'(2));
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  // State and output registers, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.addr_out = addr_q;
  assign bus.addr_vld = vld_q;
  assign bus.last     = last_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mc_burst_addr_gen.sv
// Bench for mc_burst_addr_gen: directed scenarios plus randomized bursts,
// checked every cycle against a beat-index reference model.
module tb_mc_burst_addr_gen;
  localparam int AW   = 24;
  localparam int COLW = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mc_burst_addr_gen_if #(.AW(AW)) bus ();

  mc_burst_addr_gen #(.AW(AW), .COLW(COLW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a burst is a base, a beat count, a mask and a beat index.
  bit          m_busy;
  bit          m_done;
  int          m_idx;
  int          m_n;
  logic [23:0] m_base;
  logic [23:0] m_mask;

  // Delivered beats, as observed at the consumer.
  logic [23:0] cap[$];

  function automatic logic [23:0] addr_of(logic [23:0] base, logic [23:0] mask, int idx);
    return (base & ~mask) | ((base + 24'(idx)) & mask);
  endfunction

  function automatic int beats_of(logic [2:0] bl);
    if (bl <= 3'd3) return 1 << bl;
    if (bl == 3'd7) return 1 << COLW;
    return 1;
  endfunction

  function automatic logic [23:0] mask_of(logic [2:0] bl, logic w);
    if (bl == 3'd7) return 24'((1 << COLW) - 1);
    if (w) return 24'(beats_of(bl) - 1);
    return 24'hFFFFFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_idx = 0; m_n = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (bus.start) begin
        m_busy = 1;
        m_base = bus.start_addr;
        m_n    = beats_of(bus.bl_code);
        m_mask = mask_of(bus.bl_code, bus.wrap_mode);
        m_idx  = 0;
      end
    end else begin
      m_done = 0;
      if (bus.stop || (bus.addr_rdy && m_idx == m_n - 1)) begin
        m_busy = 0;
        m_done = 1;
      end else if (bus.addr_rdy) begin
        m_idx++;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.addr_vld && bus.addr_rdy) cap.push_back(bus.addr_out);
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("vld",  32'(bus.addr_vld), 32'(m_busy));
      chk("busy", 32'(bus.busy),     32'(m_busy));
      chk("done", 32'(bus.done),     32'(m_done));
      chk("last", 32'(bus.last),     32'(m_busy && m_idx == m_n - 1));
      if (m_busy) chk("addr", 32'(bus.addr_out), 32'(addr_of(m_base, m_mask, m_idx)));
    end
  end

  function automatic logic rdy_pick(int mode, int p);
    logic [5:0] pat;
    pat = 6'b101001;
    case (mode)
      0: return 1'b1;
      1: return pat[p % 6];
      default: return ($urandom % 4) != 0;
    endcase
  endfunction

  int cap_base;

  task automatic burst(input logic [23:0] a, input logic [2:0] bl, input logic w,
                       input int rmode, input int stop_at, input bit noise);
    int p;
    bit got;
    p = 0;
    got = 0;
    cap_base = cap.size();
    @(posedge clk); #1;
    bus.start = 1; bus.start_addr = a; bus.bl_code = bl; bus.wrap_mode = w;
    bus.stop = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.addr_rdy = rdy_pick(rmode, p); p++;
    @(posedge clk); #1;
    bus.start = 0; bus.stop = 0;
    bus.start_addr = 24'($urandom); bus.bl_code = 3'($urandom); bus.wrap_mode = 1'($urandom);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (bus.done) begin got = 1; break; end
      bus.addr_rdy = rdy_pick(rmode, p); p++;
      bus.stop = (stop_at > 0 && (cap.size() - cap_base) == stop_at - 1 && bus.addr_rdy)
                 || (noise && ($urandom % 40) == 0);
      bus.start = noise && ($urandom % 5) == 0;
      @(posedge clk); #1;
    end
    bus.start = 0; bus.stop = 0; bus.addr_rdy = 0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL burst_timeout: got no done expected done within 2000 cycles");
    end
    $display("burst start=0x%06h bl=%0d wrap=%0d rdy_mode=%0d beats=%0d",
             a, bl, w, rmode, cap.size() - cap_base);
  endtask

  task automatic chk_linear(input string name, input logic [23:0] a, input int n);
    chk({name, "_count"}, 32'(cap.size() - cap_base), 32'(n));
    for (int i = 0; i < n && cap_base + i < cap.size(); i++)
      chk(name, 32'(cap[cap_base + i]), 32'(a + 24'(i)));
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1;
    bus.start = 0; bus.start_addr = '0; bus.bl_code = '0; bus.wrap_mode = 0;
    bus.stop = 0; bus.addr_rdy = 0;

    // Pin the model with hand-computed values.
    chk("model_wrap",  32'(addr_of(24'h000006, mask_of(3'd2, 1'b1), 2)), 32'h000004);
    chk("model_page",  32'(addr_of(24'h0012FE, mask_of(3'd7, 1'b0), 2)), 32'h001200);
    chk("model_lin",   32'(addr_of(24'hFFFFFF, mask_of(3'd1, 1'b0), 1)), 32'h000000);
    chk("model_beats", 32'(beats_of(3'd5)), 32'd1);

    #12;
    chk("rst_addr", 32'(bus.addr_out), 32'h0);
    chk("rst_vld",  32'(bus.addr_vld), 32'h0);
    chk("rst_last", 32'(bus.last),     32'h0);
    chk("rst_busy", 32'(bus.busy),     32'h0);
    chk("rst_done", 32'(bus.done),     32'h0);
    @(posedge clk); #1;
    rst = 0;
    // stop alone in IDLE does nothing
    bus.stop = 1;
    @(posedge clk); #1;
    bus.stop = 0;
    chk("idle_stop_busy", 32'(bus.busy), 32'h0);

    // 1: linear 8 beats across a carry
    burst(24'h0000FE, 3'd3, 1'b0, 0, 0, 0);
    chk_linear("s1", 24'h0000FE, 8);

    // 2: wrapped 4 beats
    burst(24'h000006, 3'd2, 1'b1, 0, 0, 0);
    chk("s2_count", 32'(cap.size() - cap_base), 32'd4);
    if (cap.size() - cap_base == 4) begin
      chk("s2_b0", 32'(cap[cap_base + 0]), 32'h06);
      chk("s2_b1", 32'(cap[cap_base + 1]), 32'h07);
      chk("s2_b2", 32'(cap[cap_base + 2]), 32'h04);
      chk("s2_b3", 32'(cap[cap_base + 3]), 32'h05);
    end

    // 3: full page
    burst(24'h0012FE, 3'd7, 1'b0, 0, 0, 0);
    chk("s3_count", 32'(cap.size() - cap_base), 32'd256);
    if (cap.size() - cap_base == 256) begin
      chk("s3_b2",   32'(cap[cap_base + 2]),   32'h1200);
      chk("s3_last", 32'(cap[cap_base + 255]), 32'h12FD);
    end

    // 4: stalls with rdy pattern
    burst(24'h000030, 3'd3, 1'b0, 1, 0, 0);
    chk_linear("s4", 24'h000030, 8);

    // 5: stop with xfer on beat 3, then all-ones rollover
    burst(24'h000010, 3'd3, 1'b0, 0, 3, 0);
    chk_linear("s5_stop", 24'h000010, 3);
    burst(24'hFFFFFF, 3'd1, 1'b0, 0, 0, 0);
    chk("s5_roll_count", 32'(cap.size() - cap_base), 32'd2);
    if (cap.size() - cap_base == 2)
      chk("s5_roll", 32'(cap[cap_base + 1]), 32'h000000);

    // 6: asynchronous reset mid-burst
    cap_base = cap.size();
    @(posedge clk); #1;
    bus.start = 1; bus.start_addr = 24'h000200; bus.bl_code = 3'd3; bus.wrap_mode = 0;
    bus.addr_rdy = 1;
    @(posedge clk); #1;
    bus.start = 0;
    for (int cyc = 0; cyc < 50 && (cap.size() - cap_base) < 3; cyc++) begin
      @(posedge clk); #1;
    end
    chk("s6_reach_beat4", 32'(cap.size() - cap_base), 32'd3);
    #3 rst = 1;
    #1;
    chk("s6_addr", 32'(bus.addr_out), 32'h0);
    chk("s6_vld",  32'(bus.addr_vld), 32'h0);
    chk("s6_busy", 32'(bus.busy),     32'h0);
    chk("s6_last", 32'(bus.last),     32'h0);
    chk("s6_done", 32'(bus.done),     32'h0);
    bus.addr_rdy = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("s6_no_done", 32'(bus.done), 32'h0);
    end
    burst(24'h0000FE, 3'd3, 1'b0, 0, 0, 0);
    chk_linear("s6_again", 24'h0000FE, 8);

    // Randomized bursts with stalls, stray starts and stops
    for (int t = 0; t < 30; t++) begin
      logic [2:0] bl;
      bl = 3'($urandom_range(0, 7));
      burst(24'($urandom), bl, 1'($urandom), 2, 0, 1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
